// File: rtl/dff_pipe.sv
// Valid/ready pipeline of DEPTH valid-qualified registers with bubble collapse
// and synchronous flush; used for retiming and latency balancing.
module dff_pipe #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           din,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] d [DEPTH];
    logic             take;

    // A stage may load when it is empty or everything downstream of it moves.
    always_comb begin
        logic ripple;
        adv    = '0;
        ripple = !v[DEPTH-1] | out_ready;
        adv[DEPTH-1] = ripple;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            ripple = !v[i] | ripple;
            adv[i] = ripple;
        end
    end

    assign in_ready = adv[0] & ~flush;
    assign take     = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d[i] <= RST_VAL;
            end
        end else if (flush) begin
            v <= '0;
        end else begin
            if (adv[0]) begin
                v[0] <= take;
                if (take) begin
                    d[0] <= din;
                end
            end
            // Bubbles advance their valid bit only; data registers keep the last word.
            for (int i = 1; i < DEPTH; i++) begin
                if (adv[i]) begin
                    v[i] <= v[i-1];
                    if (v[i-1]) begin
                        d[i] <= d[i-1];
                    end
                end
            end
        end
    end

    assign out_valid = v[DEPTH-1];
    assign dout      = d[DEPTH-1];

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(v[i]);
        end
    end

endmodule
